// File: rtl/ball_capture_ctrl.sv
// Snapshot controller for the ball detector: freezes ball_ram after one captured
// frame, with optional periodic re-snap and a deferred return to live writing.
module ball_capture_ctrl #(
   parameter int unsigned FRAME_LINES = 480,
   parameter int unsigned CNT_W       = 10
) (
   input  logic       iVgaClk,
   input  logic       reset,
   input  logic       iVgaHRequest,
   input  logic       iVgaVRequest,
   input  logic       iSnapReq,
   input  logic       iLiveReq,
   input  logic [7:0] iAutoPeriod,
   output logic       oFreezeRam,
   output logic       oVideoSelect,
   output logic       oCaptureBusy,
   output logic       oSnapDone,
   output logic       oShortFrame,
   output logic [7:0] oFrameCount
);

   typedef enum logic [1:0] {
      LIVE     = 2'd0,
      WAIT_SOF = 2'd1,
      CAPTURE  = 2'd2,
      FROZEN   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LINES_FULL = CNT_W'(FRAME_LINES);
   localparam logic [CNT_W-1:0] LINES_LAST = CNT_W'(FRAME_LINES - 1);

   state_t           state, state_nxt;
   logic             h_prev, v_prev;
   logic [CNT_W-1:0] line_cnt, line_nxt;
   logic [7:0]       auto_cnt, auto_nxt;
   logic             pend_live, pend_nxt;
   logic             done_nxt, short_nxt, cap_end;
   logic             sof, eof, eol;

   assign sof = iVgaVRequest & ~v_prev;
   assign eof = ~iVgaVRequest & v_prev;
   assign eol = ~iVgaHRequest & h_prev & iVgaVRequest;

   // State register, counters and registered outputs (outputs follow next state)
   always_ff @(posedge iVgaClk or posedge reset) begin
      if (reset) begin
         state        <= LIVE;
         h_prev       <= 1'b0;
         v_prev       <= 1'b0;
         line_cnt     <= '0;
         auto_cnt     <= '0;
         pend_live    <= 1'b0;
         oFreezeRam   <= 1'b0;
         oVideoSelect <= 1'b0;
         oCaptureBusy <= 1'b0;
         oSnapDone    <= 1'b0;
         oShortFrame  <= 1'b0;
         oFrameCount  <= '0;
      end else begin
         state        <= state_nxt;
         h_prev       <= iVgaHRequest;
         v_prev       <= iVgaVRequest;
         line_cnt     <= line_nxt;
         auto_cnt     <= auto_nxt;
         pend_live    <= pend_nxt;
         oFreezeRam   <= (state_nxt == WAIT_SOF) || (state_nxt == FROZEN);
         oVideoSelect <= (state_nxt != LIVE);
         oCaptureBusy <= (state_nxt == WAIT_SOF) || (state_nxt == CAPTURE);
         oSnapDone    <= done_nxt;
         oShortFrame  <= short_nxt;
         if (sof) oFrameCount <= oFrameCount + 8'd1;
      end
   end

   // Next-state logic; iLiveReq takes priority over iSnapReq everywhere
   always_comb begin
      state_nxt = state;
      line_nxt  = line_cnt;
      auto_nxt  = auto_cnt;
      pend_nxt  = pend_live;
      done_nxt  = 1'b0;
      short_nxt = oShortFrame;
      cap_end   = 1'b0;
      case (state)
         LIVE: begin
            if (!iLiveReq && iSnapReq) state_nxt = WAIT_SOF;
         end
         WAIT_SOF: begin
            if (iLiveReq) begin
               state_nxt = LIVE;
            end else if (sof) begin
               state_nxt = CAPTURE;
               line_nxt  = '0;
               pend_nxt  = 1'b0;
            end
         end
         CAPTURE: begin
            if (iLiveReq) pend_nxt = 1'b1;
            if (eol && (line_cnt < LINES_FULL)) line_nxt = line_cnt + CNT_W'(1);
            if (eol && (line_cnt == LINES_LAST)) begin
               cap_end   = 1'b1;
               short_nxt = 1'b0;
            end else if (eof && (line_cnt < LINES_FULL)) begin
               cap_end   = 1'b1;
               short_nxt = 1'b1;
            end
            // A live request seen at any point during the capture defers to its end
            if (cap_end) begin
               done_nxt = 1'b1;
               pend_nxt = 1'b0;
               auto_nxt = '0;
               state_nxt = (pend_live || iLiveReq) ? LIVE : FROZEN;
            end
         end
         FROZEN: begin
            if (iLiveReq) begin
               state_nxt = LIVE;
            end else if (iSnapReq) begin
               state_nxt = WAIT_SOF;
            end else if ((iAutoPeriod != 8'd0) && sof) begin
               auto_nxt = auto_cnt + 8'd1;
               if ((auto_cnt + 8'd1) == iAutoPeriod) state_nxt = WAIT_SOF;
            end
         end
         default: state_nxt = LIVE;
      endcase
   end

endmodule

// File: tb/tb_ball_capture_ctrl.sv
// Directed bench for ball_capture_ctrl: snap, short frame, deferred live,
// auto re-snap, request priority, mid-capture reset and frame-count wrap.
module tb_ball_capture_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       hreq, vreq, snap_req, live_req;
   logic [7:0] auto_period;
   logic       freeze_ram, video_select, capture_busy, snap_done, short_frame;
   logic [7:0] frame_count;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int done_base;
   logic sof_freeze, sof_busy, last_done, eof_done;

   always #5 clk = ~clk;

   ball_capture_ctrl #(.FRAME_LINES(480), .CNT_W(10)) dut (
      .iVgaClk      (clk),
      .reset        (reset),
      .iVgaHRequest (hreq),
      .iVgaVRequest (vreq),
      .iSnapReq     (snap_req),
      .iLiveReq     (live_req),
      .iAutoPeriod  (auto_period),
      .oFreezeRam   (freeze_ram),
      .oVideoSelect (video_select),
      .oCaptureBusy (capture_busy),
      .oSnapDone    (snap_done),
      .oShortFrame  (short_frame),
      .oFrameCount  (frame_count)
   );

   always @(negedge clk) if (snap_done) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One line: 4 active pixels, 2 blank; the first blank cycle is the EOL
   task automatic do_line(input logic live_pulse);
      hreq = 1'b1;
      live_req = live_pulse;
      tick();
      live_req = 1'b0;
      repeat (3) tick();
      hreq = 1'b0;
      tick();
      last_done = snap_done;
      tick();
   endtask

   task automatic frame(input int lines, input int live_at);
      vreq = 1'b0;
      hreq = 1'b0;
      repeat (3) tick();
      vreq = 1'b1;
      tick();
      sof_freeze = freeze_ram;
      sof_busy   = capture_busy;
      for (int i = 0; i < lines; i++) do_line(i == live_at);
      vreq = 1'b0;
      tick();
      eof_done = snap_done;
      tick();
   endtask

   task automatic pulse_snap();
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_freeze"}, int'(freeze_ram), 0);
      check({tag, "_video"}, int'(video_select), 0);
      check({tag, "_busy"}, int'(capture_busy), 0);
      check({tag, "_done"}, int'(snap_done), 0);
      check({tag, "_short"}, int'(short_frame), 0);
      check({tag, "_fcnt"}, int'(frame_count), 0);
   endtask

   initial begin
      reset = 1'b1;
      hreq = 1'b0; vreq = 1'b0; snap_req = 1'b0; live_req = 1'b0;
      auto_period = 8'd0;
      repeat (3) tick();
      check_idle_outputs("rst");
      reset = 1'b0;
      tick();

      // Snap requested mid-frame waits for the next SOF, then a full frame
      vreq = 1'b1;
      tick();
      do_line(1'b0); do_line(1'b0);
      pulse_snap();
      check("wait_freeze", int'(freeze_ram), 1);
      check("wait_video", int'(video_select), 1);
      check("wait_busy", int'(capture_busy), 1);
      do_line(1'b0); do_line(1'b0);
      vreq = 1'b0;
      tick();
      check("wait_hold_busy", int'(capture_busy), 1);
      done_base = done_cnt;
      frame(480, -1);
      check("cap_sof_freeze", int'(sof_freeze), 0);
      check("cap_sof_busy", int'(sof_busy), 1);
      check("full_done_at_eol", int'(last_done), 1);
      check("full_short", int'(short_frame), 0);
      check("full_freeze", int'(freeze_ram), 1);
      check("full_video", int'(video_select), 1);
      check("full_busy", int'(capture_busy), 0);
      check("full_done_cnt", done_cnt - done_base, 1);
      check("full_fcnt", int'(frame_count), 2);

      // Short frame: V drops after 200 lines
      done_base = done_cnt;
      pulse_snap();
      frame(200, -1);
      check("short_done_at_eof", int'(eof_done), 1);
      tick();
      check("short_flag", int'(short_frame), 1);
      check("short_freeze", int'(freeze_ram), 1);
      check("short_video", int'(video_select), 1);
      check("short_busy", int'(capture_busy), 0);
      check("short_done_cnt", done_cnt - done_base, 1);

      // Live request during capture defers to end of capture
      done_base = done_cnt;
      pulse_snap();
      frame(480, 100);
      check("plive_done", int'(last_done), 1);
      check("plive_short", int'(short_frame), 0);
      check("plive_freeze", int'(freeze_ram), 0);
      check("plive_video", int'(video_select), 0);
      check("plive_busy", int'(capture_busy), 0);
      check("plive_done_cnt", done_cnt - done_base, 1);

      // Auto re-snap every 3 frames
      pulse_snap();
      frame(480, -1);
      auto_period = 8'd3;
      done_base = done_cnt;
      frame(10, -1);
      check("auto1_busy", int'(sof_busy), 0);
      frame(10, -1);
      check("auto2_busy", int'(sof_busy), 0);
      frame(10, -1);
      check("auto3_sof_busy", int'(sof_busy), 1);
      check("auto3_sof_freeze", int'(sof_freeze), 1);
      check("auto3_no_done", done_cnt - done_base, 0);
      frame(480, -1);
      check("auto4_sof_freeze", int'(sof_freeze), 0);
      check("auto4_done", int'(last_done), 1);
      check("auto4_frozen", int'(freeze_ram), 1);
      auto_period = 8'd0;
      done_base = done_cnt;
      for (int i = 0; i < 4; i++) frame(10, -1);
      check("auto0_busy", int'(capture_busy), 0);
      check("auto0_freeze", int'(freeze_ram), 1);
      check("auto0_no_done", done_cnt - done_base, 0);

      // Simultaneous snap and live in FROZEN, then in LIVE
      snap_req = 1'b1; live_req = 1'b1;
      tick();
      check("both_frozen_freeze", int'(freeze_ram), 0);
      check("both_frozen_video", int'(video_select), 0);
      tick();
      snap_req = 1'b0; live_req = 1'b0;
      check("both_live_busy", int'(capture_busy), 0);

      // Reset at line 100 of a capture aborts without a done pulse
      pulse_snap();
      vreq = 1'b0;
      repeat (3) tick();
      vreq = 1'b1;
      tick();
      for (int i = 0; i < 100; i++) do_line(1'b0);
      check("pre_rst_busy", int'(capture_busy), 1);
      done_base = done_cnt;
      hreq = 1'b1;
      tick();
      reset = 1'b1;
      #1;
      check_idle_outputs("midrst");
      tick();
      hreq = 1'b0; vreq = 1'b0;
      tick();
      reset = 1'b0;
      repeat (5) tick();
      check_idle_outputs("postrst");
      check("midrst_no_done", done_cnt - done_base, 0);

      // 257 SOFs wrap the frame counter to 1
      for (int i = 0; i < 257; i++) begin
         vreq = 1'b0;
         tick();
         vreq = 1'b1;
         tick();
      end
      check("fcnt_wrap", int'(frame_count), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ball_capture_ctrl.md
BALL_CAPTURE_CTRL -- requirements
Module: ball_capture_ctrl

Interface
- REQ-001 The module SHALL have parameter FRAME_LINES, default 480, meaning the number of active lines in one complete captured frame.
- REQ-002 The module SHALL have parameter CNT_W, default 10, meaning the width of the internal line counter.
- REQ-003 The module SHALL have port iVgaClk, input, 1 bit: the single clock; all state changes occur on its rising edge.
- REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-005 The module SHALL have port iVgaHRequest, input, 1 bit: high during the active pixels of a line.
- REQ-006 The module SHALL have port iVgaVRequest, input, 1 bit: high during the active lines of a frame.
- REQ-007 The module SHALL have port iSnapReq, input, 1 bit: a one-cycle pulse requesting a single-frame capture into ball_ram.
- REQ-008 The module SHALL have port iLiveReq, input, 1 bit: a one-cycle pulse requesting a return to continuous (live) RAM writing.
- REQ-009 The module SHALL have port iAutoPeriod, input, 8 bits: the number of frames to wait in FROZEN before an automatic re-snap; 0 disables auto re-snap.
- REQ-010 The module SHALL have port oFreezeRam, output, 1 bit, registered: drives the ball_detector iFreezeRam input.
- REQ-011 The module SHALL have port oVideoSelect, output, 1 bit, registered: drives the ball_detector iVideoSelect input.
- REQ-012 The module SHALL have port oCaptureBusy, output, 1 bit, registered: high while in WAIT_SOF or CAPTURE.
- REQ-013 The module SHALL have port oSnapDone, output, 1 bit, registered: a one-cycle pulse when a capture ends.
- REQ-014 The module SHALL have port oShortFrame, output, 1 bit, registered: valid with oSnapDone; 1 means the frame ended before FRAME_LINES lines.
- REQ-015 The module SHALL have port oFrameCount, output, 8 bits, registered: counts start-of-frame events and wraps from 255 to 0.

Function
- REQ-016 The module SHALL register iVgaHRequest and iVgaVRequest once, giving hPrev and vPrev.
- REQ-017 SOF SHALL be true in any cycle where iVgaVRequest=1 and vPrev=0.
- REQ-018 EOF SHALL be true in any cycle where iVgaVRequest=0 and vPrev=1.
- REQ-019 EOL SHALL be true in any cycle where iVgaHRequest=0, hPrev=1 and iVgaVRequest=1.
- REQ-020 The state machine SHALL have exactly four states: LIVE, WAIT_SOF, CAPTURE, FROZEN.
- REQ-021 Outputs SHALL take these values per state:
  - LIVE: oFreezeRam=0, oVideoSelect=0.
  - WAIT_SOF: oFreezeRam=1, oVideoSelect=1.
  - CAPTURE: oFreezeRam=0, oVideoSelect=1.
  - FROZEN: oFreezeRam=1, oVideoSelect=1.
  - All outputs SHALL take effect in the cycle after the state register changes.
- REQ-022 Transitions from LIVE: on iSnapReq go to WAIT_SOF; on iLiveReq stay in LIVE.
- REQ-023 Transitions from WAIT_SOF:
  - iLiveReq goes to LIVE.
  - Otherwise, SOF goes to CAPTURE and clears the line counter to 0.
- REQ-024 CAPTURE SHALL increment the line counter by 1 on each EOL.
- REQ-025 CAPTURE SHALL go to FROZEN, pulse oSnapDone and set oShortFrame=0 when an EOL brings the line count to FRAME_LINES.
- REQ-026 CAPTURE SHALL go to FROZEN, pulse oSnapDone and set oShortFrame=1 on EOF with the line count below FRAME_LINES.
- REQ-027 In CAPTURE, iSnapReq SHALL be ignored.
- REQ-028 In CAPTURE, iLiveReq SHALL set a pending-live flag.
  - When the capture ends with the flag set, the module SHALL pulse oSnapDone and go to LIVE instead of FROZEN.
  - The flag SHALL then be cleared.
- REQ-029 Transitions from FROZEN:
  - iLiveReq goes to LIVE.
  - iSnapReq goes to WAIT_SOF.
  - Otherwise, if iAutoPeriod≠0, the auto counter SHALL increment on each SOF.
  - When the auto counter equals iAutoPeriod, the module SHALL go to WAIT_SOF.
  - Entering FROZEN SHALL clear the auto counter.
- REQ-030 When iSnapReq and iLiveReq are both high in the same cycle, iLiveReq SHALL win in every state.
- REQ-031 oFrameCount SHALL increment on every SOF regardless of state.
- REQ-032 The line counter SHALL saturate at FRAME_LINES and never wrap.
- REQ-033 oShortFrame SHALL hold its value until the next oSnapDone.

Reset
- REQ-034 While reset is high, the module SHALL force:
  - state=LIVE, oFreezeRam=0, oVideoSelect=0;
  - oCaptureBusy=0, oSnapDone=0, oShortFrame=0, oFrameCount=0;
  - line counter=0, auto counter=0, pending-live flag=0;
  - hPrev=0, vPrev=0.
- REQ-035 A reset asserted mid-capture SHALL abort the capture without producing an oSnapDone pulse.

Verification
- REQ-036 Reset, then iSnapReq in LIVE mid-frame, then a full 480-line frame -> response:
  - oFreezeRam=1 in WAIT_SOF;
  - oFreezeRam=0 from the cycle after SOF;
  - oSnapDone pulses one cycle after the 480th EOL with oShortFrame=0;
  - oFreezeRam=1 and oVideoSelect=1 afterward.
- REQ-037 Capture with iVgaVRequest dropping after 200 lines -> oSnapDone with oShortFrame=1, state FROZEN.
- REQ-038 iLiveReq during CAPTURE -> capture completes, oSnapDone pulses, then LIVE with oFreezeRam=0 and oVideoSelect=0.
- REQ-039 FROZEN with iAutoPeriod=3 -> re-enters WAIT_SOF at the third SOF and captures the fourth frame; iAutoPeriod=0 -> stays FROZEN indefinitely.
- REQ-040 iSnapReq and iLiveReq high in the same cycle in FROZEN -> LIVE.
- REQ-041 Reset asserted at line 100 of a capture -> all outputs at reset values, no oSnapDone pulse.
- REQ-042 257 SOFs after reset -> oFrameCount=1.
